// File: rtl/sdrc_mcb_sram_rsp.sv
// sdrc_mcb_sram_rsp: MCB-side responder that stands in for the SDRAM back-end with an on-chip RAM.
// Latency: first mcb_wdat_req WR_LAT cycles after busy rises, first mcb_rdat_vld RD_LAT cycles after busy rises.
// Backpressure: none toward data; new requests are refused (ignored) while mcb_busy is high.
//
// Ports:
//   mcb_clk, mcb_rst_n            clock, asynchronous active-low reset
//   mcb_bb/wr_n/bl/ba/ra/ca       one-cycle burst request: direction, length code, address
//   mcb_busy                      high from the cycle after acceptance until the burst is done
//   mcb_wdat_req / mcb_wdat       write-beat request; data is presented the following cycle
//   mcb_rdat / mcb_rdat_vld       read beats; mcb_rdat holds its last value between bursts
//   stat_wr_beats/stat_rd_beats   saturating beat counters, cleared only by reset
module sdrc_mcb_sram_rsp #(
  parameter int MCB_B_W = 2,
  parameter int MCB_R_W = 13,
  parameter int MCB_C_W = 9,
  parameter int MCB_D_W = 16,
  parameter int MEM_AW  = 8,
  parameter int WR_LAT  = 1,
  parameter int RD_LAT  = 2
) (
  input  logic               mcb_clk,
  input  logic               mcb_rst_n,
  input  logic               mcb_bb,
  input  logic               mcb_wr_n,
  input  logic [1:0]         mcb_bl,
  input  logic [MCB_B_W-1:0] mcb_ba,
  input  logic [MCB_R_W-1:0] mcb_ra,
  input  logic [MCB_C_W-1:0] mcb_ca,
  output logic               mcb_busy,
  output logic               mcb_wdat_req,
  input  logic [MCB_D_W-1:0] mcb_wdat,
  output logic [MCB_D_W-1:0] mcb_rdat,
  output logic               mcb_rdat_vld,
  output logic [15:0]        stat_wr_beats,
  output logic [15:0]        stat_rd_beats
);

  localparam int                DEPTH     = 1 << MEM_AW;
  localparam logic [2:0]        WR_LAT_M1 = 3'(WR_LAT - 1);
  localparam logic [2:0]        RD_LAT_M1 = 3'(RD_LAT - 1);
  localparam logic [MEM_AW-1:0] ADDR_ONE  = MEM_AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LAT,
    ST_WR_REQ,
    ST_WR_TAIL,
    ST_RD_LAT,
    ST_RD_DATA
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_lat_cnt;
  logic [2:0]          w_lat_cnt_nxt;
  logic [2:0]          r_beat;
  logic [2:0]          w_beat_nxt;
  logic [2:0]          r_last;        // beat index of the final beat (N-1)
  logic [2:0]          w_bl_last;
  logic [MEM_AW-1:0]   r_addr;        // write-capture pointer or next read address
  logic                r_wcap;        // mcb_wdat carries a beat this cycle
  logic [MCB_D_W-1:0]  r_rdat;
  logic [15:0]         r_stat_wr;
  logic [15:0]         r_stat_rd;
  logic [MCB_D_W-1:0]  r_ram [DEPTH];

  logic                w_accept;
  logic                w_rd_en;
  logic [MEM_AW-1:0]   w_req_addr;
  logic [MEM_AW-1:0]   w_rd_addr;

  // RAM address is the low MEM_AW bits of the flattened {bank,row,col}.
  assign w_req_addr = MEM_AW'({mcb_ba, mcb_ra, mcb_ca});
  assign w_accept   = mcb_bb && (r_state == ST_IDLE);

  always_comb begin
    w_bl_last = 3'd0;
    case (mcb_bl)
      2'b00:   w_bl_last = 3'd0;
      2'b01:   w_bl_last = 3'd7;
      2'b10:   w_bl_last = 3'd3;
      default: w_bl_last = 3'd1;
    endcase
  end

  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= 3'd0;
      r_beat    <= 3'd0;
    end else begin
      r_state   <= w_next;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_beat    <= w_beat_nxt;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_beat_nxt    = r_beat;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_lat_cnt_nxt = 3'd0;
          w_beat_nxt    = 3'd0;
          if (!mcb_wr_n) w_next = (WR_LAT == 0) ? ST_WR_REQ  : ST_WR_LAT;
          else           w_next = (RD_LAT == 0) ? ST_RD_DATA : ST_RD_LAT;
        end
      end
      ST_WR_LAT: begin
        if (r_lat_cnt == WR_LAT_M1) begin
          w_next        = ST_WR_REQ;
          w_lat_cnt_nxt = 3'd0;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + 3'd1;
        end
      end
      ST_WR_REQ: begin
        if (r_beat == r_last) begin
          w_next     = ST_WR_TAIL;
          w_beat_nxt = 3'd0;
        end else begin
          w_beat_nxt = r_beat + 3'd1;
        end
      end
      // The last beat's data is on mcb_wdat this cycle; busy drops after it is written.
      ST_WR_TAIL: w_next = ST_IDLE;
      ST_RD_LAT: begin
        if (r_lat_cnt == RD_LAT_M1) begin
          w_next        = ST_RD_DATA;
          w_lat_cnt_nxt = 3'd0;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + 3'd1;
        end
      end
      ST_RD_DATA: begin
        if (r_beat == r_last) begin
          w_next     = ST_IDLE;
          w_beat_nxt = 3'd0;
        end else begin
          w_beat_nxt = r_beat + 3'd1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The RAM read for each beat is launched on the edge that enters (or stays in) RD_DATA,
  // so the registered RAM output lines up with mcb_rdat_vld. With RD_LAT=0 the first read
  // happens on the accept edge and must use the incoming address directly.
  assign w_rd_en   = (w_next == ST_RD_DATA);
  assign w_rd_addr = (r_state == ST_IDLE) ? w_req_addr : r_addr;

  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_addr    <= '0;
      r_last    <= 3'd0;
      r_wcap    <= 1'b0;
      r_rdat    <= '0;
      r_stat_wr <= 16'd0;
      r_stat_rd <= 16'd0;
    end else begin
      r_wcap <= (r_state == ST_WR_REQ);
      if (w_accept) r_last <= w_bl_last;
      if (w_rd_en)       r_addr <= w_rd_addr + ADDR_ONE;
      else if (w_accept) r_addr <= w_req_addr;
      else if (r_wcap)   r_addr <= r_addr + ADDR_ONE;
      if (w_rd_en) r_rdat <= r_ram[w_rd_addr];
      if (r_wcap && (r_stat_wr != 16'hFFFF)) r_stat_wr <= r_stat_wr + 16'd1;
      if ((r_state == ST_RD_DATA) && (r_stat_rd != 16'hFFFF)) r_stat_rd <= r_stat_rd + 16'd1;
    end
  end

  // RAM contents survive reset; a reset mid-burst stops further captures via r_wcap.
  always_ff @(posedge mcb_clk) begin
    if (r_wcap) r_ram[r_addr] <= mcb_wdat;
  end

  assign mcb_busy      = (r_state != ST_IDLE);
  assign mcb_wdat_req  = (r_state == ST_WR_REQ);
  assign mcb_rdat_vld  = (r_state == ST_RD_DATA);
  assign mcb_rdat      = r_rdat;
  assign stat_wr_beats = r_stat_wr;
  assign stat_rd_beats = r_stat_rd;

endmodule

// File: tb/tb_sdrc_mcb_sram_rsp.sv
// Directed bench for sdrc_mcb_sram_rsp with WR_LAT=1, RD_LAT=2, MEM_AW=8.
module tb_sdrc_mcb_sram_rsp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bb = 1'b0;
  logic        wr_n = 1'b1;
  logic [1:0]  bl = 2'b00;
  logic [1:0]  ba = '0;
  logic [12:0] ra = '0;
  logic [8:0]  ca = '0;
  logic        busy;
  logic        wdat_req;
  logic [15:0] wdat = '0;
  logic [15:0] rdat;
  logic        rdat_vld;
  logic [15:0] st_wr;
  logic [15:0] st_rd;

  int tests = 0;
  int fails = 0;
  int wreq_cnt = 0;
  int overlap = 0;
  logic [15:0] wq[$];
  logic [15:0] rq[$];

  sdrc_mcb_sram_rsp #(
    .MCB_B_W(2), .MCB_R_W(13), .MCB_C_W(9), .MCB_D_W(16),
    .MEM_AW(8), .WR_LAT(1), .RD_LAT(2)
  ) dut (
    .mcb_clk      (clk),
    .mcb_rst_n    (rst_n),
    .mcb_bb       (bb),
    .mcb_wr_n     (wr_n),
    .mcb_bl       (bl),
    .mcb_ba       (ba),
    .mcb_ra       (ra),
    .mcb_ca       (ca),
    .mcb_busy     (busy),
    .mcb_wdat_req (wdat_req),
    .mcb_wdat     (wdat),
    .mcb_rdat     (rdat),
    .mcb_rdat_vld (rdat_vld),
    .stat_wr_beats(st_wr),
    .stat_rd_beats(st_rd)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: request count, overlap of req/vld, captured read beats.
  always @(negedge clk) begin
    if (wdat_req) wreq_cnt++;
    if (wdat_req && rdat_vld) overlap++;
    if (rdat_vld) rq.push_back(rdat);
  end

  // Initiator data path: present the next queued word the cycle after each request.
  always @(negedge clk) begin
    if (wdat_req) begin
      @(posedge clk);
      #1;
      if (wq.size() > 0) wdat = wq.pop_front();
      else               wdat = 16'hDEAD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle request; returns in cycle A+1.
  task automatic issue(input logic w_n, input logic [1:0] b, input logic [7:0] a);
    bb   = 1'b1;
    wr_n = w_n;
    bl   = b;
    ba   = '0;
    ra   = '0;
    ca   = {1'b0, a};
    tick();
    bb   = 1'b0;
  endtask

  // Counts busy cycles until busy drops (bounded); returns in the first idle cycle.
  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk(tag, busy, 1'b0);
  endtask

  function automatic logic [15:0] rq_at(input int i);
    if (i < rq.size()) return rq[i];
    return 16'hxxxx;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int w0;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", wdat_req, 1'b0);
    chk("rst_vld", rdat_vld, 1'b0);
    chk("rst_rdat", rdat, 16'h0);
    chk("rst_stwr", st_wr, 16'h0);
    chk("rst_strd", st_rd, 16'h0);
    rst_n = 1'b1;
    tick();

    // Single write, 1 beat at 5: busy A+1..A+3, req only at A+2
    wq.push_back(16'hA5A5);
    issue(1'b0, 2'b00, 8'h05);
    chk("w1_a1_busy", busy, 1'b1);
    chk("w1_a1_req", wdat_req, 1'b0);
    tick();
    chk("w1_a2_busy", busy, 1'b1);
    chk("w1_a2_req", wdat_req, 1'b1);
    tick();
    chk("w1_a3_busy", busy, 1'b1);
    chk("w1_a3_req", wdat_req, 1'b0);
    tick();
    chk("w1_a4_busy", busy, 1'b0);
    chk("w1_stwr", st_wr, 16'd1);

    // Single read at 5: vld only at A+3, rdat held afterward
    rq.delete();
    issue(1'b1, 2'b00, 8'h05);
    chk("r1_a1_vld", rdat_vld, 1'b0);
    tick();
    chk("r1_a2_vld", rdat_vld, 1'b0);
    tick();
    chk("r1_a3_vld", rdat_vld, 1'b1);
    chk("r1_a3_rdat", rdat, 16'hA5A5);
    chk("r1_a3_busy", busy, 1'b1);
    tick();
    chk("r1_a4_vld", rdat_vld, 1'b0);
    chk("r1_a4_busy", busy, 1'b0);
    chk("r1_hold", rdat, 16'hA5A5);
    chk("r1_strd", st_rd, 16'd1);

    // 8-beat write at 0 (data 0..7), then 8-beat read
    for (int i = 0; i < 8; i++) wq.push_back(16'(i));
    w0 = wreq_cnt;
    issue(1'b0, 2'b01, 8'h00);
    wait_idle("w8_idle", n);
    chk("w8_busy_cycles", n, 10);
    chk("w8_reqs", wreq_cnt - w0, 8);
    chk("w8_stwr", st_wr, 16'd9);
    rq.delete();
    issue(1'b1, 2'b01, 8'h00);
    chk("r8_a1_vld", rdat_vld, 1'b0);
    tick();
    chk("r8_a2_vld", rdat_vld, 1'b0);
    tick();
    chk("r8_a3_vld", rdat_vld, 1'b1);
    wait_idle("r8_idle", n);
    chk("r8_vld_cycles", n, 8);
    chk("r8_count", rq.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("r8_d%0d", i), rq_at(i), 16'(i));
    chk("r8_strd", st_rd, 16'd9);

    // Address wrap: 8 beats from 0xFC, read 0x01 -> 6th word 0x15
    for (int i = 0; i < 8; i++) wq.push_back(16'h10 + 16'(i));
    issue(1'b0, 2'b01, 8'hFC);
    wait_idle("wrap_w_idle", n);
    rq.delete();
    issue(1'b1, 2'b00, 8'h01);
    wait_idle("wrap_r_idle", n);
    chk("wrap_data", rq_at(0), 16'h15);
    chk("wrap_stwr", st_wr, 16'd17);

    // Request while busy is ignored
    wq.push_back(16'hBEEF);
    issue(1'b0, 2'b00, 8'h50);
    wait_idle("ign_pre_idle", n);
    for (int i = 0; i < 4; i++) wq.push_back(16'h20 + 16'(i));
    w0 = wreq_cnt;
    issue(1'b0, 2'b10, 8'h40);
    tick();
    bb = 1'b1; wr_n = 1'b0; bl = 2'b00; ca = 9'h050;
    tick();
    bb = 1'b0;
    wait_idle("ign_idle", n);
    chk("ign_reqs", wreq_cnt - w0, 4);
    chk("ign_stwr", st_wr, 16'd22);
    rq.delete();
    issue(1'b1, 2'b00, 8'h50);
    wait_idle("ign_r50_idle", n);
    issue(1'b1, 2'b10, 8'h40);
    wait_idle("ign_r40_idle", n);
    chk("ign_addr50", rq_at(0), 16'hBEEF);
    for (int i = 0; i < 4; i++) chk($sformatf("ign_d%0d", i), rq_at(i + 1), 16'h20 + 16'(i));
    chk("ign_strd", st_rd, 16'd15);

    // Back-to-back: each request issued the cycle busy drops
    for (int i = 0; i < 16; i++) wq.push_back(16'h100 + 16'(i));
    w0 = wreq_cnt;
    issue(1'b0, 2'b01, 8'h00);
    wait_idle("b2b_w0_idle", n);
    chk("b2b_w0_busy", n, 10);
    issue(1'b0, 2'b01, 8'h08);
    wait_idle("b2b_w1_idle", n);
    chk("b2b_w1_busy", n, 10);
    chk("b2b_reqs", wreq_cnt - w0, 16);
    rq.delete();
    issue(1'b1, 2'b01, 8'h00);
    wait_idle("b2b_r0_idle", n);
    chk("b2b_r0_busy", n, 10);
    issue(1'b1, 2'b01, 8'h08);
    wait_idle("b2b_r1_idle", n);
    chk("b2b_r1_busy", n, 10);
    chk("b2b_count", rq.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("b2b_d%0d", i), rq_at(i), 16'h100 + 16'(i));
    chk("b2b_stwr", st_wr, 16'd38);
    chk("b2b_strd", st_rd, 16'd31);

    // Reset during beat 3 of an 8-beat read
    issue(1'b1, 2'b01, 8'h00);
    tick(); tick();
    tick(); tick(); tick();
    chk("mrst_pre_vld", rdat_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", rdat_vld, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_req", wdat_req, 1'b0);
    chk("mrst_strd", st_rd, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rq.delete();
    issue(1'b1, 2'b00, 8'h03);
    wait_idle("post_idle", n);
    chk("post_busy", n, 3);
    chk("post_count", rq.size(), 1);
    chk("post_data", rq_at(0), 16'h103);
    chk("post_strd", st_rd, 16'd1);
    chk("post_stwr", st_wr, 16'd0);

    chk("no_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdrc_mcb_sram_rsp.md
Name: sdrc_mcb_sram_rsp

Overview:
- Synthesizable MCB-side responder that emulates the SDRAM back-end with an on-chip RAM.
- Accepts burst requests from MCB initiators (test TX/RX generators, front-end arbiters) and issues mcb_wdat_req for write bursts.
- Returns read bursts on mcb_rdat/mcb_rdat_vld.
- Used for loopback bring-up of MCB clients without the SDRAM controller or device.

Parameters:
- MCB_B_W, 2, bank address width
- MCB_R_W, 13, row address width
- MCB_C_W, 9, column address width
- MCB_D_W, 16, data width
- MEM_AW, 8, internal RAM address width; RAM depth is 2^MEM_AW words
- WR_LAT, 1, cycles from busy rise to first mcb_wdat_req (range 0..7)
- RD_LAT, 2, cycles from busy rise to first mcb_rdat_vld (range 0..7)

Ports:
- mcb_clk  in  1  clock
- mcb_rst_n  in  1  reset
- mcb_bb  in  1  burst request strobe, one cycle
- mcb_wr_n  in  1  0 = write, 1 = read; qualified by mcb_bb
- mcb_bl  in  2  burst length code
- mcb_ba  in  MCB_B_W  bank address
- mcb_ra  in  MCB_R_W  row address
- mcb_ca  in  MCB_C_W  column address
- mcb_busy  out  1  responder busy; requests are ignored while high
- mcb_wdat_req  out  1  write-data beat request
- mcb_wdat  in  MCB_D_W  write data, valid the cycle after mcb_wdat_req
- mcb_rdat  out  MCB_D_W  read data
- mcb_rdat_vld  out  1  read-data beat valid
- stat_wr_beats  out  16  count of written beats, saturating
- stat_rd_beats  out  16  count of read beats, saturating

Behaviour:
- Reset: mcb_rst_n is asynchronous, active-low; clock is mcb_clk. On reset, all outputs are 0 and the FSM goes to IDLE. RAM contents are not cleared.
- Reset mid-burst aborts the burst immediately. Only beats already captured remain written.
- Burst length by mcb_bl: 00 = 1 beat, 01 = 8, 10 = 4, 11 = 2.
- RAM address: low MEM_AW bits of {ba,ra,ca}. Each beat increments the address by 1, wrapping modulo 2^MEM_AW.
- Acceptance: on edge A, mcb_bb=1 and mcb_busy=0. The responder latches wr_n, bl and the address, and mcb_busy=1 from A+1.
- Any mcb_bb while busy=1 is ignored and no state changes.
- FSM states: IDLE, WR_LAT, WR_REQ, WR_TAIL, RD_LAT, RD_DATA.
- IDLE: on accept, go to WR_LAT or RD_LAT; otherwise stay.
- WR_LAT: hold WR_LAT cycles via a 3-bit latency counter, then go to WR_REQ. With WR_LAT=0, go directly to WR_REQ on the accept edge.
- WR_REQ:
  - mcb_wdat_req=1 for exactly N consecutive cycles (beat counter 0..N-1).
  - mcb_wdat is sampled one cycle after each req cycle and written to RAM at base+k.
  - After the N-th req, go to WR_TAIL.
- WR_TAIL: capture beat N-1, drop mcb_busy on the next edge, go to IDLE.
- Write timing, N beats: busy is high for WR_LAT+N+1 cycles.
- RD_LAT: hold RD_LAT cycles, then go to RD_DATA. The RAM read is issued one cycle ahead so data aligns with vld (synchronous RAM, 1-cycle read).
- RD_DATA:
  - mcb_rdat_vld=1 for N consecutive cycles, with mcb_rdat = RAM[base+k].
  - mcb_busy falls on the same edge that vld falls; return to IDLE.
- mcb_rdat holds its last value when vld=0.
- Read-after-write: a read accepted the cycle busy falls after a write returns the newly written data. The RAM write of the last beat completes before the first read access.
- mcb_wdat_req and mcb_rdat_vld are never high together.
- Stat counters:
  - stat_wr_beats +1 per captured write beat; stat_rd_beats +1 per vld beat.
  - Both saturate at 16'hFFFF and clear only on reset.

Test Plan:
- Single write, bl=00, addr {0,0,5}, wdat 16'hA5A5, WR_LAT=1 -> busy high cycles A+1..A+3; wdat_req only at A+2; stat_wr_beats=1.
- Write 8 beats (bl=01) at addr 0, data 0..7, then read bl=01 at addr 0 -> wdat_req high 8 consecutive cycles; rdat_vld 8 cycles starting A+3, data 0,1,...,7 in order; stat_rd_beats=8.
- Wrap: write bl=01 at RAM addr 8'hFC with data 0x10..0x17, then read 1 beat at 8'h01 -> returns 0x15 (wrapped).
- mcb_bb pulsed during an active write -> ignored; no extra wdat_req; second burst's address not written.
- Back-to-back: 16-beat initiator (two bl=01 writes, then two reads at 0 and 8) issuing bb the cycle busy drops -> all 16 words read back match; no gap cycle violation.
- Assert mcb_rst_n=0 during beat 3 of an 8-beat read -> rdat_vld, busy and wdat_req go 0 immediately; after release a new 1-beat read completes normally.
